em_exc_stage: RTL and testbench
===============================

# em_exc_stage

E/M pipeline register plus M-stage exception merge for the P8 MIPS CPU with CP0. Latches the E-stage instruction, ALU result and E-stage exception status every cycle, with stall and flush. In M it checks load/store alignment and the address map, and presents one prioritised exception (code, EPC, BD) to CP0. It also produces a gated memory write-enable so a faulting store never reaches DM or timer registers.

## Interface
Parameters
- DM_TOP, 32'h0000_2FFF, last valid DM byte address (DM starts at 0)
- TC0_BASE, 32'h0000_7F00, timer 0 base (3 words)
- TC1_BASE, 32'h0000_7F10, timer 1 base (3 words)

Ports
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hold all M registers
- flush  in  1  load a bubble into M (CP0 exception/eret); wins over stall
- E_PC  in  32  PC of E instruction
- E_Instr  in  32  E instruction word
- E_BD  in  1  E instruction is in a delay slot
- E_ExcGet  in  1  exception already detected (F/D/E)
- E_ExcCode  in  5  code for E_ExcGet
- E_ALUOut  in  32  ALU result / effective address
- E_WriteData  in  32  store data (forwarded rt)
- M_PC, M_Instr, M_ALUOut, M_WriteData  out  32 each  registered copies
- M_BD  out  1  registered
- M_Valid  out  1  registered; 1 = real instruction, 0 = bubble
- M_ExcGet  out  1  final M exception (combinational from registers)
- M_ExcCode  out  5  final code
- M_EPC  out  32  M_BD ? M_PC-4 : M_PC
- M_MemWE  out  1  store enable to DM/timers

## Operation
- Register update on posedge clk, priority: flush > stall > load.
  - Load: all M registers take the E values; M_Valid <= 1.
  - Flush: M_Instr, M_ALUOut, M_WriteData, M_PC, M_BD, M_Valid and the latched exception fields go to 0.
  - Stall: all registers hold.
- Decode from M_Instr opcode:
  - Loads: LW, LH, LHU, LB, LBU.
  - Stores: SW, SH, SB.
  - Anything else is not a memory operation.
- Let A = M_ALUOut. The M check fires only when the latched upstream exception is 0 and the instruction is a load or store. Load violations give AdEL (4); store violations give AdES (5).
  - Misaligned: word access with A[1:0] != 0, or half access with A[0] != 0.
  - Out of map: A is not in [0, DM_TOP], not in [TC0_BASE, TC0_BASE+11], and not in [TC1_BASE, TC1_BASE+11].
  - Timer region accessed by a byte or half operation.
  - SW to TC0_BASE+8 or TC1_BASE+8 (COUNT is read-only); this gives AdES.
- Priority:
  - A latched upstream exception passes through unchanged. This covers OV and the address-overflow AdEL/AdES flagged in E.
  - Otherwise the M check applies.
  - Otherwise M_ExcGet = 0 and M_ExcCode = 0.
- M_MemWE = M_Valid & store & ~M_ExcGet.
- A bubble (M_Valid = 0) never raises an exception and never writes.

## Timing
- Reset (async, reset_n = 0): all registered outputs are 0 except M_PC = 32'h0000_3000. Derived outputs: M_ExcGet = 0, M_ExcCode = 0, M_MemWE = 0, M_EPC = 32'h0000_3000.
- Reset release is taken at the next clock edge with no special sequencing.
- Reset asserted mid-stall or mid-flush overrides both immediately.
- Latency: one cycle from E inputs to M registered outputs. M_ExcGet, M_ExcCode, M_EPC and M_MemWE are combinational in the same cycle from the M registers; there is no added cycle.
- stall held for N cycles keeps the outputs constant for N cycles, including M_MemWE. The memory side must tolerate a repeated write, or the hazard unit must never stall M on a store.
- flush and stall asserted in the same cycle: bubble.
- Address checks use the full 32 bits; arithmetic has no wrap. TC0_BASE+11 is computed in 32 bits.

## Test plan
- Reset, then load SW with A = 32'h0000_0010 and no E exception. Next cycle: M_Valid = 1, M_ExcGet = 0, M_MemWE = 1, M_EPC = E_PC.
- LW with A = 32'h0000_0006 → M_ExcGet = 1, M_ExcCode = 4, M_MemWE = 0. SH with A = 32'h0000_0003 → code 5.
- SW to 32'h0000_7F08 → AdES (5). LW from 32'h0000_7F08 → no exception. SB to 32'h0000_7F00 → AdES. LW from 32'h0000_3000 → AdEL.
- E_ExcGet = 1 with E_ExcCode = 12 on a misaligned SW → M_ExcCode = 12 (upstream wins) and M_MemWE = 0. With E_BD = 1 and E_PC = 32'h0000_3008 → M_EPC = 32'h0000_3004.
- Hold stall for 3 cycles while E inputs change → M outputs unchanged. Then assert flush and stall together → M_Valid = 0, M_ExcGet = 0, M_MemWE = 0.
- Drive reset_n low between clock edges during a stall → outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/em_exc_stage_if.sv
// E-side inputs and M-side outputs of the E/M pipeline register with
// the M-stage exception merge.
interface em_exc_stage_if;
    logic        stall;
    logic        flush;
    logic [31:0] E_PC;
    logic [31:0] E_Instr;
    logic        E_BD;
    logic        E_ExcGet;
    logic [4:0]  E_ExcCode;
    logic [31:0] E_ALUOut;
    logic [31:0] E_WriteData;

    logic [31:0] M_PC;
    logic [31:0] M_Instr;
    logic [31:0] M_ALUOut;
    logic [31:0] M_WriteData;
    logic        M_BD;
    logic        M_Valid;
    logic        M_ExcGet;
    logic [4:0]  M_ExcCode;
    logic [31:0] M_EPC;
    logic        M_MemWE;

    modport master (
        output stall, flush, E_PC, E_Instr, E_BD, E_ExcGet, E_ExcCode,
               E_ALUOut, E_WriteData,
        input  M_PC, M_Instr, M_ALUOut, M_WriteData, M_BD, M_Valid,
               M_ExcGet, M_ExcCode, M_EPC, M_MemWE
    );

    modport slave (
        input  stall, flush, E_PC, E_Instr, E_BD, E_ExcGet, E_ExcCode,
               E_ALUOut, E_WriteData,
        output M_PC, M_Instr, M_ALUOut, M_WriteData, M_BD, M_Valid,
               M_ExcGet, M_ExcCode, M_EPC, M_MemWE
    );
endinterface

// File: rtl/em_exc_stage.sv
// E/M pipeline register plus M-stage address checks and exception merge;
// gates the memory write so a faulting store never reaches DM or timers.
module em_exc_stage #(
    parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
    input logic           clk,
    input logic           reset_n,
    em_exc_stage_if.slave bus
);
    localparam logic [31:0] TC0_END   = TC0_BASE + 32'd11;
    localparam logic [31:0] TC1_END   = TC1_BASE + 32'd11;
    localparam logic [31:0] TC0_COUNT = TC0_BASE + 32'd8;
    localparam logic [31:0] TC1_COUNT = TC1_BASE + 32'd8;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic        bd;
    logic        valid;
    logic        up_exc_get;
    logic [4:0]  up_exc_code;

    // Flush beats stall; a flushed slot carries no upstream exception.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            instr       <= '0;
            alu_out     <= '0;
            write_data  <= '0;
            bd          <= 1'b0;
            valid       <= 1'b0;
            up_exc_get  <= 1'b0;
            up_exc_code <= '0;
        end else if (bus.flush) begin
            pc          <= '0;
            instr       <= '0;
            alu_out     <= '0;
            write_data  <= '0;
            bd          <= 1'b0;
            valid       <= 1'b0;
            up_exc_get  <= 1'b0;
            up_exc_code <= '0;
        end else if (!bus.stall) begin
            pc          <= bus.E_PC;
            instr       <= bus.E_Instr;
            alu_out     <= bus.E_ALUOut;
            write_data  <= bus.E_WriteData;
            bd          <= bus.E_BD;
            valid       <= 1'b1;
            up_exc_get  <= bus.E_ExcGet;
            up_exc_code <= bus.E_ExcCode;
        end
    end

    logic is_load;
    logic is_store;
    logic is_word;
    logic is_half;
    logic is_byte;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_word  = 1'b0;
        is_half  = 1'b0;
        is_byte  = 1'b0;
        case (instr[31:26])
            6'h23: begin is_load  = 1'b1; is_word = 1'b1; end
            6'h21: begin is_load  = 1'b1; is_half = 1'b1; end
            6'h25: begin is_load  = 1'b1; is_half = 1'b1; end
            6'h20: begin is_load  = 1'b1; is_byte = 1'b1; end
            6'h24: begin is_load  = 1'b1; is_byte = 1'b1; end
            6'h2B: begin is_store = 1'b1; is_word = 1'b1; end
            6'h29: begin is_store = 1'b1; is_half = 1'b1; end
            6'h28: begin is_store = 1'b1; is_byte = 1'b1; end
            default: ;
        endcase
    end

    logic in_dm;
    logic in_tc0;
    logic in_tc1;
    logic in_timer;
    logic misaligned;
    logic out_of_map;
    logic timer_narrow;
    logic count_write;
    logic m_check;
    logic exc_get;

    assign in_dm        = (alu_out <= DM_TOP);
    assign in_tc0       = (alu_out >= TC0_BASE) && (alu_out <= TC0_END);
    assign in_tc1       = (alu_out >= TC1_BASE) && (alu_out <= TC1_END);
    assign in_timer     = in_tc0 | in_tc1;
    assign misaligned   = (is_word & (alu_out[1:0] != 2'b00)) | (is_half & alu_out[0]);
    assign out_of_map   = ~(in_dm | in_timer);
    assign timer_narrow = in_timer & (is_half | is_byte);
    // COUNT registers are read-only; only a word store can address them legally.
    assign count_write  = is_store & is_word & ((alu_out == TC0_COUNT) | (alu_out == TC1_COUNT));
    assign m_check      = (is_load | is_store) &
                          (misaligned | out_of_map | timer_narrow | count_write);

    assign exc_get = valid & (up_exc_get | m_check);

    assign bus.M_PC        = pc;
    assign bus.M_Instr     = instr;
    assign bus.M_ALUOut    = alu_out;
    assign bus.M_WriteData = write_data;
    assign bus.M_BD        = bd;
    assign bus.M_Valid     = valid;
    assign bus.M_ExcGet    = exc_get;
    assign bus.M_ExcCode   = !valid     ? 5'd0 :
                             up_exc_get ? up_exc_code :
                             m_check    ? (is_load ? 5'd4 : 5'd5) : 5'd0;
    assign bus.M_EPC       = bd ? (pc - 32'd4) : pc;
    assign bus.M_MemWE     = valid & is_store & ~exc_get;
endmodule

// File: tb/tb_em_exc_stage.sv
// Self-checking bench for em_exc_stage: directed vector table, hand-written
// stall/flush/async-reset sequences and randomized traffic against a model.
module tb_em_exc_stage;
    localparam logic [31:0] DM_TOP   = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

    localparam logic [5:0] OP_LW = 6'h23, OP_LH = 6'h21, OP_LHU = 6'h25,
                           OP_LB = 6'h20, OP_LBU = 6'h24, OP_SW = 6'h2B,
                           OP_SH = 6'h29, OP_SB = 6'h28, OP_ADD = 6'h00;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    em_exc_stage_if bus ();

    em_exc_stage #(
        .DM_TOP  (DM_TOP),
        .TC0_BASE(TC0_BASE),
        .TC1_BASE(TC1_BASE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr, alu, wd;
        logic        bd, valid, eget;
        logic [4:0]  ecode;
    } mstate_t;

    typedef struct {
        logic [31:0] pc, instr, alu, wd, epc;
        logic        bd, valid, eget, we;
        logic [4:0]  ecode;
    } out_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc, alu;
        logic        bd, eget;
        logic [4:0]  ecode;
        logic        x_eget, x_we;
        logic [4:0]  x_ecode;
        logic [31:0] x_epc;
    } vec_t;

    // Reference model: M slot as a plain record, advanced with flush > stall > load.
    mstate_t mdl;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mdl <= '{pc: 32'h0000_3000, instr: 0, alu: 0, wd: 0, bd: 0, valid: 0, eget: 0, ecode: 0};
        else if (bus.flush)
            mdl <= '{pc: 0, instr: 0, alu: 0, wd: 0, bd: 0, valid: 0, eget: 0, ecode: 0};
        else if (!bus.stall)
            mdl <= '{pc: bus.E_PC, instr: bus.E_Instr, alu: bus.E_ALUOut, wd: bus.E_WriteData,
                     bd: bus.E_BD, valid: 1'b1, eget: bus.E_ExcGet, ecode: bus.E_ExcCode};
    end

    function automatic out_t model_out(mstate_t s);
        out_t        o;
        int          size;
        bit          ld, st, in_dm, in_t0, in_t1, bad;
        logic [31:0] a;
        size = 0; ld = 0; st = 0;
        case (s.instr[31:26])
            OP_LW:         begin ld = 1; size = 4; end
            OP_LH, OP_LHU: begin ld = 1; size = 2; end
            OP_LB, OP_LBU: begin ld = 1; size = 1; end
            OP_SW:         begin st = 1; size = 4; end
            OP_SH:         begin st = 1; size = 2; end
            OP_SB:         begin st = 1; size = 1; end
            default: ;
        endcase
        a     = s.alu;
        in_dm = a <= DM_TOP;
        in_t0 = (a >= TC0_BASE) && (a - TC0_BASE < 12);
        in_t1 = (a >= TC1_BASE) && (a - TC1_BASE < 12);
        bad   = 0;
        if (size != 0) begin
            if (a % size != 0) bad = 1;
            if (!(in_dm || in_t0 || in_t1)) bad = 1;
            if ((in_t0 || in_t1) && size < 4) bad = 1;
            if (st && size == 4 && (a == TC0_BASE + 8 || a == TC1_BASE + 8)) bad = 1;
        end
        o.pc = s.pc; o.instr = s.instr; o.alu = s.alu; o.wd = s.wd;
        o.bd = s.bd; o.valid = s.valid;
        o.epc = s.bd ? s.pc - 4 : s.pc;
        o.eget = 0; o.ecode = 0;
        if (s.valid && s.eget) begin
            o.eget = 1; o.ecode = s.ecode;
        end else if (s.valid && (ld || st) && bad) begin
            o.eget = 1; o.ecode = ld ? 5'd4 : 5'd5;
        end
        o.we = s.valid && st && !o.eget;
        return o;
    endfunction

    task automatic applyStimulus(input logic st, input logic fl, input logic [5:0] op,
                                 input logic [31:0] pc, input logic [31:0] alu,
                                 input logic bd, input logic eget, input logic [4:0] ecode);
        logic [31:0] rnd;
        rnd = $urandom();
        bus.stall       = st;
        bus.flush       = fl;
        bus.E_PC        = pc;
        bus.E_Instr     = {op, rnd[25:0]};
        bus.E_ALUOut    = alu;
        bus.E_WriteData = $urandom();
        bus.E_BD        = bd;
        bus.E_ExcGet    = eget;
        bus.E_ExcCode   = ecode;
    endtask

    task automatic checkOutput(input string name, input out_t x);
        bit bad;
        bad = 0;
        vectors++;
        if (bus.M_PC !== x.pc) begin bad = 1;
            $display("[TB] FAIL %s M_PC got %h want %h", name, bus.M_PC, x.pc); end
        if (bus.M_Instr !== x.instr) begin bad = 1;
            $display("[TB] FAIL %s M_Instr got %h want %h", name, bus.M_Instr, x.instr); end
        if (bus.M_ALUOut !== x.alu) begin bad = 1;
            $display("[TB] FAIL %s M_ALUOut got %h want %h", name, bus.M_ALUOut, x.alu); end
        if (bus.M_WriteData !== x.wd) begin bad = 1;
            $display("[TB] FAIL %s M_WriteData got %h want %h", name, bus.M_WriteData, x.wd); end
        if (bus.M_BD !== x.bd) begin bad = 1;
            $display("[TB] FAIL %s M_BD got %b want %b", name, bus.M_BD, x.bd); end
        if (bus.M_Valid !== x.valid) begin bad = 1;
            $display("[TB] FAIL %s M_Valid got %b want %b", name, bus.M_Valid, x.valid); end
        if (bus.M_ExcGet !== x.eget) begin bad = 1;
            $display("[TB] FAIL %s M_ExcGet got %b want %b", name, bus.M_ExcGet, x.eget); end
        if (bus.M_ExcCode !== x.ecode) begin bad = 1;
            $display("[TB] FAIL %s M_ExcCode got %0d want %0d", name, bus.M_ExcCode, x.ecode); end
        if (bus.M_EPC !== x.epc) begin bad = 1;
            $display("[TB] FAIL %s M_EPC got %h want %h", name, bus.M_EPC, x.epc); end
        if (bus.M_MemWE !== x.we) begin bad = 1;
            $display("[TB] FAIL %s M_MemWE got %b want %b", name, bus.M_MemWE, x.we); end
        if (bad) miscompares++;
    endtask

    out_t reset_out, bubble_out, held, x;
    vec_t vecs[$];
    logic [5:0]  ops[11] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB,
                             OP_ADD, 6'h0F, 6'h04};
    logic [31:0] addr;

    initial begin
        reset_out  = '{pc: 32'h0000_3000, instr: 0, alu: 0, wd: 0, epc: 32'h0000_3000,
                       bd: 0, valid: 0, eget: 0, we: 0, ecode: 0};
        bubble_out = '{pc: 0, instr: 0, alu: 0, wd: 0, epc: 0,
                       bd: 0, valid: 0, eget: 0, we: 0, ecode: 0};

        //            op      pc            alu            bd eg code  xeg xwe xcode  xepc
        vecs.push_back('{OP_SW,  32'h3000, 32'h0000_0010, 0, 0, 0,    0, 1, 5'd0,  32'h3000});
        vecs.push_back('{OP_LW,  32'h3004, 32'h0000_0006, 0, 0, 0,    1, 0, 5'd4,  32'h3004});
        vecs.push_back('{OP_SH,  32'h3008, 32'h0000_0003, 0, 0, 0,    1, 0, 5'd5,  32'h3008});
        vecs.push_back('{OP_SW,  32'h300C, 32'h0000_7F08, 0, 0, 0,    1, 0, 5'd5,  32'h300C});
        vecs.push_back('{OP_LW,  32'h3010, 32'h0000_7F08, 0, 0, 0,    0, 0, 5'd0,  32'h3010});
        vecs.push_back('{OP_SB,  32'h3014, 32'h0000_7F00, 0, 0, 0,    1, 0, 5'd5,  32'h3014});
        vecs.push_back('{OP_LW,  32'h3018, 32'h0000_3000, 0, 0, 0,    1, 0, 5'd4,  32'h3018});
        vecs.push_back('{OP_SW,  32'h3008, 32'h0000_0011, 1, 1, 12,   1, 0, 5'd12, 32'h3004});
        vecs.push_back('{OP_SW,  32'h3020, 32'h0000_7F14, 0, 0, 0,    0, 1, 5'd0,  32'h3020});
        vecs.push_back('{OP_SW,  32'h3024, 32'h0000_7F18, 0, 0, 0,    1, 0, 5'd5,  32'h3024});
        vecs.push_back('{OP_LB,  32'h3028, 32'h0000_2FFF, 0, 0, 0,    0, 0, 5'd0,  32'h3028});
        vecs.push_back('{OP_LH,  32'h302C, 32'h0000_2FFE, 1, 0, 0,    0, 0, 5'd0,  32'h3028});
        vecs.push_back('{OP_LHU, 32'h3030, 32'h0000_3000, 0, 0, 0,    1, 0, 5'd4,  32'h3030});
        vecs.push_back('{OP_SW,  32'h3034, 32'h0000_7F0C, 0, 0, 0,    1, 0, 5'd5,  32'h3034});
        vecs.push_back('{OP_ADD, 32'h3038, 32'h0000_0003, 0, 0, 0,    0, 0, 5'd0,  32'h3038});
        vecs.push_back('{OP_LW,  32'h303C, 32'hFFFF_FFFC, 0, 0, 0,    1, 0, 5'd4,  32'h303C});
        vecs.push_back('{OP_LBU, 32'h3040, 32'h0000_7F11, 0, 0, 0,    1, 0, 5'd4,  32'h3040});
        vecs.push_back('{OP_SW,  32'h3044, 32'h0000_7EFC, 0, 0, 0,    1, 0, 5'd5,  32'h3044});
        vecs.push_back('{OP_SB,  32'h3048, 32'h0000_0007, 0, 1, 0,    1, 0, 5'd0,  32'h3048});

        applyStimulus(0, 0, OP_ADD, 0, 0, 0, 0, 0);
        #12;
        checkOutput("reset", reset_out);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(0, 0, vecs[i].op, vecs[i].pc, vecs[i].alu,
                          vecs[i].bd, vecs[i].eget, vecs[i].ecode);
            x = '{pc: vecs[i].pc, instr: bus.E_Instr, alu: vecs[i].alu, wd: bus.E_WriteData,
                  epc: vecs[i].x_epc, bd: vecs[i].bd, valid: 1'b1, eget: vecs[i].x_eget,
                  we: vecs[i].x_we, ecode: vecs[i].x_ecode};
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), x);
        end

        // Stall three cycles while the E side keeps changing.
        applyStimulus(0, 0, OP_SW, 32'h3100, 32'h0000_0020, 0, 0, 0);
        held = '{pc: 32'h3100, instr: bus.E_Instr, alu: 32'h20, wd: bus.E_WriteData,
                 epc: 32'h3100, bd: 0, valid: 1, eget: 0, we: 1, ecode: 0};
        @(negedge clk);
        checkOutput("stall_load", held);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, OP_LW, 32'h3200 + i * 4, 32'h0000_0006, 1, 1, 5'd12);
            @(negedge clk);
            checkOutput($sformatf("stall_hold%0d", i), held);
        end
        applyStimulus(1, 1, OP_SW, 32'h3300, 32'h0000_0040, 0, 0, 0);
        @(negedge clk);
        checkOutput("flush_and_stall", bubble_out);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: addr = $urandom();
                1: addr = $urandom_range(0, 32'h2FFF);
                2: addr = 32'h2FF8 + $urandom_range(0, 15);
                3: addr = 32'h7EFC + $urandom_range(0, 19);
                4: addr = 32'h7F0C + $urandom_range(0, 19);
                default: addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            endcase
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                          ops[$urandom_range(0, 10)], $urandom() & 32'hFFFF_FFFC, addr,
                          $urandom_range(0, 1), $urandom_range(0, 9) == 0,
                          5'($urandom_range(0, 31)));
            @(negedge clk);
            checkOutput($sformatf("rand%0d", i), model_out(mdl));
        end

        // Asynchronous reset in the middle of a stalled cycle.
        applyStimulus(0, 0, OP_SW, 32'h3400, 32'h0000_0030, 0, 0, 0);
        @(negedge clk);
        bus.stall = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 checkOutput("async_reset", reset_out);
        @(negedge clk);
        checkOutput("reset_hold", reset_out);
        reset_n = 1'b1;
        applyStimulus(0, 0, OP_SW, 32'h3500, 32'h0000_0100, 0, 0, 0);
        x = '{pc: 32'h3500, instr: bus.E_Instr, alu: 32'h100, wd: bus.E_WriteData,
              epc: 32'h3500, bd: 0, valid: 1, eget: 0, we: 1, ecode: 0};
        @(negedge clk);
        checkOutput("after_reset", x);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
